db_press_classifier: RTL and testbench

DB_PRESS_CLASSIFIER -- requirements
Module: DB_press_classifier

---
 rtl/db_pkg.sv | 6 +
 rtl/db_edge_detect.sv | 28 ++
 rtl/db_press_classifier.sv | 84 ++++++++
 tb/tb_db_press_classifier.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/db_pkg.sv
// db_pkg: shared state encoding and default timing limits for the press classifier
package db_pkg;
  typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND} state_t;
  localparam int LONG_LIMIT_DEF = 8;
  localparam int GAP_LIMIT_DEF = 4;
endpackage

// File: rtl/db_edge_detect.sv
// db_edge_detect: registers the debounced level and flags its rising edge
module db_edge_detect #(
  parameter logic PREV_RST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_level,
  output logic o_rise
);
  logic r_in_ff;
  logic r_in_prev;
  logic r_armed;
  // in_prev keeps its reset value until in_ff has sampled real input once, so a level held through reset is not a rise
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_in_ff   <= 1'b0;
      r_in_prev <= PREV_RST;
      r_armed   <= 1'b0;
    end else begin
      r_in_ff   <= i_level;
      r_in_prev <= r_armed ? r_in_ff : PREV_RST;
      r_armed   <= 1'b1;
    end
  end
  assign o_level = r_in_ff;
  assign o_rise  = r_in_ff & ~r_in_prev;
endmodule

// File: rtl/db_press_classifier.sv
// db_press_classifier: classifies button presses into short, long and double with registered pulse outputs
module db_press_classifier
  import db_pkg::*;
#(
  parameter int LONG_LIMIT = LONG_LIMIT_DEF,
  parameter int GAP_LIMIT  = GAP_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic signal,
  output logic press_o,
  output logic short_o,
  output logic long_o,
  output logic double_o,
  output logic held_o
);
  localparam int CW = $clog2(LONG_LIMIT > GAP_LIMIT ? LONG_LIMIT : GAP_LIMIT) + 1;
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_LIMIT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LIMIT - 1);
  state_t r_state;
  state_t w_next;
  logic [CW-1:0] r_ctr;
  logic [CW-1:0] w_ctr_next;
  logic w_level, w_rise, w_inc;
  logic w_press, w_short, w_long, w_double;
  db_edge_detect #(.PREV_RST(1'b1)) u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (signal),
    .o_level (w_level),
    .o_rise  (w_rise)
  );
  // next-state and event decode; a press in WAIT_SECOND wins over gap expiry
  always_comb begin
    w_next   = r_state;
    w_inc    = 1'b0;
    w_press  = 1'b0;
    w_short  = 1'b0;
    w_long   = 1'b0;
    w_double = 1'b0;
    case (r_state)
      IDLE: begin
        w_next  = w_rise ? PRESSED : IDLE;
        w_press = w_rise;
      end
      PRESSED: begin
        w_next = !w_level ? WAIT_SECOND : (r_ctr == LONG_LAST) ? LONG_HELD : PRESSED;
        w_long = w_level && r_ctr == LONG_LAST;
        w_inc  = w_level && r_ctr != LONG_LAST;
      end
      LONG_HELD: w_next = w_level ? LONG_HELD : IDLE;
      WAIT_SECOND: begin
        w_next   = w_level ? SECOND : (r_ctr == GAP_LAST) ? IDLE : WAIT_SECOND;
        w_double = w_level;
        w_press  = w_level;
        w_short  = !w_level && r_ctr == GAP_LAST;
        w_inc    = !w_level && r_ctr != GAP_LAST;
      end
      SECOND: w_next = w_level ? SECOND : IDLE;
      default: w_next = IDLE;
    endcase
    w_ctr_next = (w_next != r_state) ? '0 : r_ctr + CW'(w_inc);
  end
  // state, counter and registered outputs; reset drops any classification in progress
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_ctr    <= '0;
      press_o  <= 1'b0;
      short_o  <= 1'b0;
      long_o   <= 1'b0;
      double_o <= 1'b0;
      held_o   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_ctr    <= w_ctr_next;
      press_o  <= w_press;
      short_o  <= w_short;
      long_o   <= w_long;
      double_o <= w_double;
      held_o   <= w_next inside {PRESSED, LONG_HELD, SECOND};
    end
  end
endmodule

// File: tb/tb_db_press_classifier.sv
// tb_db_press_classifier: scoreboard bench for press/short/long/double classification
module tb_db_press_classifier;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signal = 1'b0;
  logic press_o, short_o, long_o, double_o, held_o;
  int cyc = 0;
  int vectors = 0;
  int errors = 0;
  typedef struct {int cyc; int kind;} ev_t;
  ev_t exp_q[$];
  string kind_name[4] = '{"press", "short", "long", "double"};
  db_press_classifier #(.LONG_LIMIT(8), .GAP_LIMIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .signal   (signal),
    .press_o  (press_o),
    .short_o  (short_o),
    .long_o   (long_o),
    .double_o (double_o),
    .held_o   (held_o)
  );
  always #5 clk = ~clk;
  // edge index: after posedge n, cyc == n
  always @(posedge clk) cyc <= cyc + 1;
  // pop and compare one expected event per observed pulse, in press/short/long/double order
  always @(negedge clk) begin : mon
    logic [3:0] p;
    ev_t e;
    p = {double_o, long_o, short_o, press_o};
    vectors++;
    if ($countones(p[3:1]) > 1) begin
      errors++;
      $display("FAIL exclusive: short/long/double=%b at cycle %0d, required at most one high", p[3:1], cyc);
    end
    for (int k = 0; k < 4; k++) begin
      if (p[k] === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_%s: pulse at cycle %0d, required none", kind_name[k], cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc !== cyc || e.kind !== k) begin
            errors++;
            $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d", kind_name[k], cyc, kind_name[e.kind], e.cyc);
          end
        end
      end
    end
  end
  task automatic push(input int c, input int k);
    ev_t e;
    e.cyc = c;
    e.kind = k;
    exp_q.push_back(e);
  endtask
  task automatic drive(input logic v, input int n);
    repeat (n) begin
      signal = v;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset();
    signal = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({press_o, short_o, long_o, double_o, held_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 00000", {press_o, short_o, long_o, double_o, held_o});
    end
    rst = 1'b1;
    drive(1'b0, 3);
  endtask
  task automatic test_short();
    int s;
    s = cyc + 1;
    push(s + 1, 0);
    push(s + 8, 1);
    drive(1'b1, 3);
    drive(1'b0, 12);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL short_drain: %0d expected pulses missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_long();
    int s;
    s = cyc + 1;
    push(s + 1, 0);
    push(s + 9, 2);
    for (int i = 0; i < 30; i++) begin
      signal = (i < 20);
      @(posedge clk);
      #1;
      vectors++;
      if (held_o !== (i >= 1 && i <= 20)) begin
        errors++;
        $display("FAIL long_held: held_o=%b at cycle %0d, required %b", held_o, cyc, (i >= 1 && i <= 20));
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL long_drain: %0d expected pulses missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_long_boundary();
    int s;
    s = cyc + 1;
    push(s + 1, 0);
    push(s + 13, 1);
    drive(1'b1, 8);
    drive(1'b0, 10);
    s = cyc + 1;
    push(s + 1, 0);
    push(s + 9, 2);
    drive(1'b1, 9);
    drive(1'b0, 10);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL boundary_drain: %0d expected pulses missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_double();
    int s;
    s = cyc + 1;
    push(s + 1, 0);
    push(s + 6, 0);
    push(s + 6, 3);
    drive(1'b1, 3);
    drive(1'b0, 2);
    drive(1'b1, 3);
    drive(1'b0, 12);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL double_drain: %0d expected pulses missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_gap_tie();
    int s;
    s = cyc + 1;
    push(s + 1, 0);
    push(s + 8, 0);
    push(s + 8, 3);
    drive(1'b1, 3);
    drive(1'b0, 4);
    drive(1'b1, 3);
    drive(1'b0, 12);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL tie_drain: %0d expected pulses missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_gap_expired();
    int s;
    s = cyc + 1;
    push(s + 1, 0);
    push(s + 8, 1);
    push(s + 9, 0);
    push(s + 16, 1);
    drive(1'b1, 3);
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 12);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL expired_drain: %0d expected pulses missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_second_long();
    int s;
    s = cyc + 1;
    push(s + 1, 0);
    push(s + 6, 0);
    push(s + 6, 3);
    drive(1'b1, 3);
    drive(1'b0, 2);
    drive(1'b1, 20);
    drive(1'b0, 12);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL second_drain: %0d expected pulses missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset_mid();
    int s;
    s = cyc + 1;
    push(s + 1, 0);
    drive(1'b1, 4);
    vectors++;
    if (held_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_held: held_o=%b before reset, required 1", held_o);
    end
    rst = 1'b0;
    drive(1'b1, 1);
    vectors++;
    if ({press_o, short_o, long_o, double_o, held_o} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b, required 00000", {press_o, short_o, long_o, double_o, held_o});
    end
    drive(1'b1, 1);
    rst = 1'b1;
    drive(1'b1, 10);
    vectors++;
    if (held_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_held_after: held_o=%b with button held through reset, required 0", held_o);
    end
    drive(1'b0, 2);
    s = cyc + 1;
    push(s + 1, 0);
    push(s + 8, 1);
    drive(1'b1, 3);
    drive(1'b0, 12);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_drain: %0d expected pulses missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  initial begin
    test_reset();
    test_short();
    test_long();
    test_long_boundary();
    test_double();
    test_gap_tie();
    test_gap_expired();
    test_second_long();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
